ps2_kbd_fifo: RTL and testbench

PS2_KBD_FIFO -- requirements
Module: ps2_kbd_fifo

---
 rtl/ps2_kbd_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/ps2_kbd_fifo.sv | 147 ++++++++++++++
 tb/tb_ps2_kbd_fifo.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_kbd_pkg.sv
// Shared constants for the PS/2 keyboard scancode FIFO: register map,
// STATUS/CTRL bit positions and the scancode type.
package ps2_kbd_pkg;

    typedef logic [7:0] scancode_t;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_ERRCNT = 2'd3;

    localparam int ST_NEMPTY  = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 8;

    localparam int CTRL_IRQ_EN  = 0;
    localparam int CTRL_CLR_OVF = 1;
    localparam int CTRL_FLUSH   = 2;

    // STATUS only has an 8-bit count field; deeper FIFOs pin it at 255.
    function automatic logic [7:0] sat_cnt8(input int unsigned cnt);
        logic [31:0] c;
        c = cnt;
        return (c > 32'd255) ? 8'hFF : c[7:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with (log2(DEPTH)+1)-bit wrapping pointers; the storage
// array is not reset, only the pointers are.
module sync_fifo
    import ps2_kbd_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_din,
    output logic [WIDTH-1:0]           o_dout,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             rd_en;
    logic             wr_en;

    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign o_count = wr_ptr - rd_ptr;
    assign o_dout  = mem[rd_ptr[AW-1:0]];

    // A pop frees the slot this cycle, so a push into a full FIFO is legal then.
    assign rd_en = i_pop && !o_empty;
    assign wr_en = i_push && (!o_full || rd_en);

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= i_din;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_fifo.sv
// PS/2 scancode receiver FIFO with a 4-register bus interface and level IRQ.
// Define PS2_KBD_FIFO_ERRCNT_EN to build in the frame-error counter.
module ps2_kbd_fifo
    import ps2_kbd_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int ERRCNT_W = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_kbd_code,
    input  logic        i_kbd_strobe,
    input  logic        i_kbd_err,
    input  logic        i_sel,
    input  logic        i_we,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_irq
);

    localparam int AW = $clog2(DEPTH);

    logic              kbd_low_q;
    logic              kbd_rise;
    logic              push;
    logic              pop;
    logic              flush;
    logic              rd_acc;
    logic              wr_acc;
    logic              ctrl_wr;
    logic              ovf;
    logic              irq_en;
    logic              full;
    logic              empty;
    logic [AW:0]       count;
    scancode_t         head;
    logic [ERRCNT_W-1:0] errcnt;
    logic [31:0]       rd_mux;
    logic              unused_wdata;

    assign unused_wdata = &{1'b0, i_wdata[31:3], 1'b0};

    // Holds "strobe was seen low"; clearing it on reset means a strobe that is
    // already high when reset releases is not taken as a new arrival.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            kbd_low_q <= 1'b0;
        end else begin
            kbd_low_q <= !i_kbd_strobe;
        end
    end

    assign kbd_rise = i_kbd_strobe && kbd_low_q;
    assign push     = kbd_rise && !i_kbd_err;

    assign rd_acc  = i_sel && !i_we;
    assign wr_acc  = i_sel && i_we;
    assign ctrl_wr = wr_acc && (i_addr == ADDR_CTRL);
    assign pop     = rd_acc && (i_addr == ADDR_DATA) && !empty;
    assign flush   = ctrl_wr && i_wdata[CTRL_FLUSH];

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_pop   (pop),
        .i_flush (flush),
        .i_din   (i_kbd_code),
        .o_dout  (head),
        .o_count (count),
        .o_full  (full),
        .o_empty (empty)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            irq_en <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                irq_en <= i_wdata[CTRL_IRQ_EN];
            end
            if (ctrl_wr && i_wdata[CTRL_CLR_OVF]) begin
                ovf <= 1'b0;
            end else if (push && full && !pop && !flush) begin
                ovf <= 1'b1;
            end
        end
    end

`ifdef PS2_KBD_FIFO_ERRCNT_EN
    logic err_evt;
    assign err_evt = kbd_rise && i_kbd_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            errcnt <= '0;
        end else if (wr_acc && (i_addr == ADDR_ERRCNT)) begin
            errcnt <= '0;
        end else if (err_evt && (errcnt != '1)) begin
            errcnt <= errcnt + ERRCNT_W'(1);
        end
    end
`else
    assign errcnt = '0;
`endif

    always_comb begin
        rd_mux = '0;
        case (i_addr)
            ADDR_DATA: begin
                if (!empty) begin
                    rd_mux[7:0] = head;
                end
            end
            ADDR_STATUS: begin
                rd_mux[ST_NEMPTY]          = !empty;
                rd_mux[ST_FULL]            = full;
                rd_mux[ST_OVF]             = ovf;
                rd_mux[ST_CNT_LSB +: 8]    = sat_cnt8(32'(count));
            end
            ADDR_CTRL: begin
                rd_mux[CTRL_IRQ_EN] = irq_en;
            end
            default: begin
                rd_mux = 32'(errcnt);
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rdata <= '0;
            o_irq   <= 1'b0;
        end else begin
            if (rd_acc) begin
                o_rdata <= rd_mux;
            end
            o_irq <= irq_en && (!empty || ovf);
        end
    end

endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// Scoreboard bench for ps2_kbd_fifo: reads queue their expected data, a
// monitor compares o_rdata the cycle after each read.
module tb_ps2_kbd_fifo;

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;
    localparam logic [1:0] A_ERRCNT = 2'd3;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [7:0]  i_kbd_code = '0;
    logic        i_kbd_strobe = 1'b0;
    logic        i_kbd_err = 1'b0;
    logic        i_sel = 1'b0;
    logic        i_we = 1'b0;
    logic [1:0]  i_addr = '0;
    logic [31:0] i_wdata = '0;
    logic [31:0] o_rdata;
    logic        o_irq;

    ps2_kbd_fifo #(.DEPTH(16), .ERRCNT_W(8)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_kbd_code   (i_kbd_code),
        .i_kbd_strobe (i_kbd_strobe),
        .i_kbd_err    (i_kbd_err),
        .i_sel        (i_sel),
        .i_we         (i_we),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .o_rdata      (o_rdata),
        .o_irq        (o_irq)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    logic rd_cap;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rd_cap <= 1'b0;
        else          rd_cap <= i_sel && !i_we;
    end

    always @(negedge i_clk) begin
        exp_t e;
        if (rd_cap) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_read: rdata=%h, no expectation queued", o_rdata);
            end else begin
                e = exp_q.pop_front();
                if (o_rdata !== e.val) begin
                    n_miss++;
                    $display("FAIL %s: rdata=%h expected=%h", e.name, o_rdata, e.val);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
        exp_t x;
        x.name = nm;
        x.val  = e;
        exp_q.push_back(x);
        i_sel  = 1'b1;
        i_we   = 1'b0;
        i_addr = a;
        @(negedge i_clk);
        i_sel  = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        i_sel   = 1'b1;
        i_we    = 1'b1;
        i_addr  = a;
        i_wdata = d;
        @(negedge i_clk);
        i_sel   = 1'b0;
        i_we    = 1'b0;
    endtask

    task automatic strobe(input logic [7:0] code, input logic err);
        i_kbd_code   = code;
        i_kbd_err    = err;
        i_kbd_strobe = 1'b1;
        @(negedge i_clk);
        i_kbd_strobe = 1'b0;
        @(negedge i_clk);
        i_kbd_err    = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t x;
        repeat (3) @(negedge i_clk);
        check("reset_rdata", o_rdata, 32'h0);
        check("reset_irq", {31'b0, o_irq}, 32'h0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        rd(A_STATUS, 32'h0, "status_after_reset");

        // Basic ordering
        strobe(8'h1C, 1'b0);
        strobe(8'hF0, 1'b0);
        strobe(8'h1C, 1'b0);
        rd(A_DATA, 32'h1C, "order_0");
        rd(A_DATA, 32'hF0, "order_1");
        rd(A_DATA, 32'h1C, "order_2");
        rd(A_STATUS, 32'h0, "order_status_empty");
        rd(A_DATA, 32'h0, "data_read_empty");
        rd(A_STATUS, 32'h0, "empty_read_no_change");

        // Overflow
        for (int i = 0; i < 17; i++) strobe(8'(i), 1'b0);
        rd(A_STATUS, 32'h0000_1007, "ovf_status_full");
        for (int i = 0; i < 16; i++) rd(A_DATA, 32'(i), "ovf_drain");
        rd(A_STATUS, 32'h0000_0004, "ovf_sticky");
        wr(A_CTRL, 32'h2);
        rd(A_STATUS, 32'h0, "ovf_cleared");

        // Frame errors and ignored writes
        strobe(8'h55, 1'b1);
        rd(A_STATUS, 32'h0, "err_not_pushed");
`ifdef PS2_KBD_FIFO_ERRCNT_EN
        rd(A_ERRCNT, 32'h1, "errcnt_one");
        for (int i = 0; i < 254; i++) strobe(8'h55, 1'b1);
        rd(A_ERRCNT, 32'hFF, "errcnt_max");
        strobe(8'h55, 1'b1);
        rd(A_ERRCNT, 32'hFF, "errcnt_saturated");
        wr(A_ERRCNT, 32'h1234);
        rd(A_ERRCNT, 32'h0, "errcnt_cleared");
`else
        rd(A_ERRCNT, 32'h0, "errcnt_absent");
        wr(A_ERRCNT, 32'h1234);
        rd(A_ERRCNT, 32'h0, "errcnt_write_ignored");
`endif
        wr(A_DATA, 32'hAB);
        wr(A_STATUS, 32'hFFFF_FFFF);
        rd(A_STATUS, 32'h0, "data_status_write_ignored");

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 16; i++) strobe(8'h40 + 8'(i), 1'b0);
        rd(A_STATUS, 32'h0000_1003, "full_status");
        x.name = "full_pushpop_head";
        x.val  = 32'h40;
        exp_q.push_back(x);
        i_kbd_code   = 8'h99;
        i_kbd_strobe = 1'b1;
        i_sel        = 1'b1;
        i_we         = 1'b0;
        i_addr       = A_DATA;
        @(negedge i_clk);
        i_sel        = 1'b0;
        i_kbd_strobe = 1'b0;
        @(negedge i_clk);
        rd(A_STATUS, 32'h0000_1003, "full_pushpop_status");
        for (int i = 1; i < 16; i++) rd(A_DATA, 32'h40 + 32'(i), "full_pushpop_drain");
        rd(A_DATA, 32'h99, "full_pushpop_last");
        rd(A_STATUS, 32'h0, "full_pushpop_empty");

        // Interrupt timing
        wr(A_CTRL, 32'h1);
        rd(A_CTRL, 32'h1, "ctrl_irq_en");
        check("irq_idle", {31'b0, o_irq}, 32'h0);
        i_kbd_code   = 8'h2A;
        i_kbd_strobe = 1'b1;
        @(negedge i_clk);
        check("irq_same_cycle_as_push", {31'b0, o_irq}, 32'h0);
        i_kbd_strobe = 1'b0;
        @(negedge i_clk);
        check("irq_after_push", {31'b0, o_irq}, 32'h1);
        x.name = "irq_data";
        x.val  = 32'h2A;
        exp_q.push_back(x);
        i_sel  = 1'b1;
        i_we   = 1'b0;
        i_addr = A_DATA;
        @(negedge i_clk);
        i_sel  = 1'b0;
        check("irq_same_cycle_as_pop", {31'b0, o_irq}, 32'h1);
        @(negedge i_clk);
        check("irq_after_pop", {31'b0, o_irq}, 32'h0);

        // Flush via CTRL also drops irq_en
        strobe(8'h11, 1'b0);
        strobe(8'h22, 1'b0);
        wr(A_CTRL, 32'h4);
        rd(A_STATUS, 32'h0, "flush_empty");
        rd(A_CTRL, 32'h0, "flush_irq_en_off");

        // Reset mid-burst with strobe held high
        wr(A_CTRL, 32'h1);
        for (int i = 0; i < 5; i++) strobe(8'hA0 + 8'(i), 1'b0);
        rd(A_STATUS, 32'h0000_0501, "pre_reset_status");
        @(negedge i_clk);
        check("pre_reset_irq", {31'b0, o_irq}, 32'h1);
        i_kbd_code   = 8'h33;
        i_kbd_strobe = 1'b1;
        i_rst_n      = 1'b0;
        #1;
        check("mid_reset_rdata", o_rdata, 32'h0);
        check("mid_reset_irq", {31'b0, o_irq}, 32'h0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);
        rd(A_STATUS, 32'h0, "held_strobe_no_push");
        check("post_reset_irq", {31'b0, o_irq}, 32'h0);
        i_kbd_strobe = 1'b0;
        @(negedge i_clk);
        strobe(8'h77, 1'b0);
        rd(A_STATUS, 32'h0000_0101, "new_edge_pushed");
        rd(A_DATA, 32'h77, "new_edge_data");

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge i_clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain_timeout: pending=%0d expected=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
